// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: MM:SS stopwatch counting BCD digits from an asynchronous
// timebase tick.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on tick_in, legal range 2..4
// Ports
//   clk_in       system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   tick_in      asynchronous timebase, one count per rising edge
//   start_stop   command pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear        command pulse: back to IDLE with count and lap zeroed
//   lap          command pulse: capture the live count (RUN/PAUSE only)
//   time_bcd     live count {min_tens, min_ones, sec_tens, sec_ones}
//   lap_bcd      captured lap count, same digit layout
//   lap_valid    lap_bcd holds a capture taken since the last clear
//   running      high while in RUN
//   wrap         one-cycle pulse on the 59:59 -> 00:00 rollover
// All outputs come straight from flops.

module bcd_stopwatch #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] time_bcd,
    output logic [15:0] lap_bcd,
    output logic        lap_valid,
    output logic        running,
    output logic        wrap
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned TIME_W  = 4 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] DIG_ONE  = DIGIT_W'(1);
    localparam logic [DIGIT_W-1:0] DIG_FIVE = DIGIT_W'(5);
    localparam logic [DIGIT_W-1:0] DIG_NINE = DIGIT_W'(9);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // ------------------------------------------------------------------
    // Tick synchronizer, history flop and post-reset arming
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   hist_q;
    logic                   arm_q;
    logic                   arm_d;
    logic                   tick_sync_c;
    logic                   count_ev_c;

    assign tick_sync_c = sync_q[SYNC_STAGES-1];

    // fill_q marks how far genuine post-reset samples have travelled down
    // the chain; arming waits for a real low so a tick already high at
    // reset release cannot count until it falls and rises again.
    assign arm_d      = arm_q | (fill_q[SYNC_STAGES-1] & ~tick_sync_c);
    assign count_ev_c = tick_sync_c & ~hist_q & arm_q;

    // Synchronizer, history and arming flops
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            hist_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            hist_q <= tick_sync_c;
            arm_q  <= arm_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [TIME_W-1:0] time_q,      time_d;
    logic [TIME_W-1:0] lap_q,       lap_d;
    logic              lap_valid_q, lap_valid_d;
    logic              running_q,   running_d;
    logic              wrap_q,      wrap_d;

    // ------------------------------------------------------------------
    // BCD increment of the live count
    // ------------------------------------------------------------------
    logic [DIGIT_W-1:0] sec_ones_c;
    logic [DIGIT_W-1:0] sec_tens_c;
    logic [DIGIT_W-1:0] min_ones_c;
    logic [DIGIT_W-1:0] min_tens_c;
    logic [TIME_W-1:0]  inc_time_c;
    logic               inc_wrap_c;

    assign sec_ones_c = time_q[3:0];
    assign sec_tens_c = time_q[7:4];
    assign min_ones_c = time_q[11:8];
    assign min_tens_c = time_q[15:12];

    // Ripple carry through the four digits; a digit at or above its limit
    // rolls to zero, so even a corrupted digit returns to BCD range.
    always_comb begin
        inc_time_c = time_q;
        inc_wrap_c = 1'b0;
        if (sec_ones_c < DIG_NINE) begin
            inc_time_c[3:0] = sec_ones_c + DIG_ONE;
        end else begin
            inc_time_c[3:0] = '0;
            if (sec_tens_c < DIG_FIVE) begin
                inc_time_c[7:4] = sec_tens_c + DIG_ONE;
            end else begin
                inc_time_c[7:4] = '0;
                if (min_ones_c < DIG_NINE) begin
                    inc_time_c[11:8] = min_ones_c + DIG_ONE;
                end else begin
                    inc_time_c[11:8] = '0;
                    if (min_tens_c < DIG_FIVE) begin
                        inc_time_c[15:12] = min_tens_c + DIG_ONE;
                    end else begin
                        inc_time_c[15:12] = '0;
                        inc_wrap_c        = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        wrap_d      = 1'b0;

        if (clear) begin
            // clear overrides start_stop, lap and any count event
            state_d     = ST_IDLE;
            time_d      = '0;
            lap_d       = '0;
            lap_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // events and laps are ignored while idle
                    if (start_stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // an event coinciding with the pause command still counts
                    if (count_ev_c) begin
                        time_d = inc_time_c;
                        wrap_d = inc_wrap_c;
                    end
                    if (lap) begin
                        lap_d       = time_q;
                        lap_valid_d = 1'b1;
                    end
                    if (start_stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    // events while paused are dropped, including on resume
                    if (lap) begin
                        lap_d       = time_q;
                        lap_valid_d = 1'b1;
                    end
                    if (start_stop) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            time_q      <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            wrap_q      <= wrap_d;
        end
    end

    assign time_bcd  = time_q;
    assign lap_bcd   = lap_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Testbench for bcd_stopwatch: a seconds-based reference model checked
// every cycle, directed scenarios with literal expectations, then random
// stimulus.

module tb_bcd_stopwatch;

    localparam int S       = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        tick_in;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] time_bcd;
    logic [15:0] lap_bcd;
    logic        lap_valid;
    logic        running;
    logic        wrap;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    bit chk_en   = 1'b0;

    // reference model state: counts in plain seconds
    int m_secs;
    int m_lap_secs;
    bit m_lv;
    bit m_wrap;
    int m_st;
    bit samp_q[$];

    bcd_stopwatch #(.SYNC_STAGES(S)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .time_bcd   (time_bcd),
        .lap_bcd    (lap_bcd),
        .lap_valid  (lap_valid),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] to_bcd(input int secs);
        int mins;
        int sec;
        mins = secs / 60;
        sec  = secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    // One clock edge of the model. A count happens S edges after the edge
    // that sampled a low->high step of tick_in, both samples taken after reset.
    task automatic model_step();
        bit ev;
        int n;
        if (rst) begin
            samp_q.delete();
            m_secs     = 0;
            m_lap_secs = 0;
            m_lv       = 1'b0;
            m_wrap     = 1'b0;
            m_st       = M_IDLE;
        end else begin
            ev = 1'b0;
            n  = samp_q.size();
            if (n >= S + 1) ev = samp_q[n-S] && !samp_q[n-S-1];
            samp_q.push_back(tick_in);
            if (samp_q.size() > S + 2) void'(samp_q.pop_front());
            m_wrap = 1'b0;
            if (clear) begin
                m_st       = M_IDLE;
                m_secs     = 0;
                m_lap_secs = 0;
                m_lv       = 1'b0;
            end else begin
                if (m_st != M_IDLE && lap) begin
                    m_lap_secs = m_secs;
                    m_lv       = 1'b1;
                end
                if (m_st == M_RUN && ev) begin
                    m_secs = (m_secs + 1) % 3600;
                    m_wrap = (m_secs == 0);
                end
                if (start_stop) m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            vec_cnt++;
            if (time_bcd !== to_bcd(m_secs) || lap_bcd !== to_bcd(m_lap_secs) ||
                lap_valid !== m_lv || running !== (m_st == M_RUN) || wrap !== m_wrap) begin
                miss_cnt++;
                $display("FAIL cycle t=%0t got time=%h lap=%h lv=%b run=%b wrap=%b want time=%h lap=%h lv=%b run=%b wrap=%b",
                         $time, time_bcd, lap_bcd, lap_valid, running, wrap,
                         to_bcd(m_secs), to_bcd(m_lap_secs), m_lv, (m_st == M_RUN), m_wrap);
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic cmd(input bit ss, input bit clr, input bit lp);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        @(negedge clk_in);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic ticks(input int n, input int hi, input int lo);
        repeat (n) begin
            tick_in = 1'b1;
            cyc(hi);
            tick_in = 1'b0;
            cyc(lo);
        end
    endtask

    initial begin
        int wraps;
        rst        = 1'b1;
        tick_in    = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        check_lit("reset-time", time_bcd, 16'h0000);
        check_lit("reset-lap", lap_bcd, 16'h0000);
        check_lit("reset-lapvalid", {15'b0, lap_valid}, 16'h0000);
        check_lit("reset-running", {15'b0, running}, 16'h0000);
        check_lit("reset-wrap", {15'b0, wrap}, 16'h0000);
        rst = 1'b0;
        cyc(1);

        // five ticks at 1/16 of the clock rate
        cmd(1'b1, 1'b0, 1'b0);
        ticks(5, 8, 8);
        check_lit("five-ticks-time", time_bcd, 16'h0005);
        check_lit("five-ticks-running", {15'b0, running}, 16'h0001);

        // minute carry, then all the way to the 59:59 rollover
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(59, 3, 3);
        check_lit("at-0059", time_bcd, 16'h0059);
        ticks(1, 3, 3);
        check_lit("carry-0100", time_bcd, 16'h0100);
        ticks(3539, 3, 3);
        check_lit("at-5959", time_bcd, 16'h5959);
        wraps   = 0;
        tick_in = 1'b1;
        repeat (8) begin
            @(negedge clk_in);
            if (wrap) wraps++;
        end
        tick_in = 1'b0;
        cyc(2);
        check_lit("wrap-pulse-count", 16'(wraps), 16'd1);
        check_lit("wrap-time", time_bcd, 16'h0000);
        check_lit("wrap-running", {15'b0, running}, 16'h0001);

        // pause issued in the same cycle as a count event
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(7, 3, 3);
        check_lit("at-0007", time_bcd, 16'h0007);
        tick_in = 1'b1;
        cyc(S);
        cmd(1'b1, 1'b0, 1'b0);
        cyc(2);
        tick_in = 1'b0;
        cyc(3);
        check_lit("pause-event-time", time_bcd, 16'h0008);
        check_lit("pause-event-running", {15'b0, running}, 16'h0000);
        ticks(3, 3, 3);
        check_lit("paused-ticks-ignored", time_bcd, 16'h0008);

        // lap capture then keep counting
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(12, 3, 3);
        cmd(1'b0, 1'b0, 1'b1);
        check_lit("lap-value", lap_bcd, 16'h0012);
        check_lit("lap-valid", {15'b0, lap_valid}, 16'h0001);
        ticks(4, 3, 3);
        check_lit("lap-after-time", time_bcd, 16'h0016);
        check_lit("lap-after-hold", lap_bcd, 16'h0012);

        // clear beats start_stop in PAUSE; long-high tick counts once
        cmd(1'b1, 1'b0, 1'b0);
        check_lit("paused-running", {15'b0, running}, 16'h0000);
        cmd(1'b1, 1'b1, 1'b0);
        check_lit("clear-time", time_bcd, 16'h0000);
        check_lit("clear-lap", lap_bcd, 16'h0000);
        check_lit("clear-lapvalid", {15'b0, lap_valid}, 16'h0000);
        check_lit("clear-running", {15'b0, running}, 16'h0000);
        cmd(1'b1, 1'b0, 1'b0);
        tick_in = 1'b1;
        cyc(100);
        tick_in = 1'b0;
        cyc(4);
        check_lit("long-high-one-event", time_bcd, 16'h0001);

        // reset in RUN at 03:41 on the edge of a pending count
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(221, 3, 3);
        check_lit("at-0341", time_bcd, 16'h0341);
        tick_in = 1'b1;
        cyc(S);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check_lit("rst-run-time", time_bcd, 16'h0000);
        check_lit("rst-run-running", {15'b0, running}, 16'h0000);
        check_lit("rst-run-lapvalid", {15'b0, lap_valid}, 16'h0000);

        // tick high across reset release must not count until it re-rises
        cmd(1'b1, 1'b0, 1'b0);
        cyc(10);
        check_lit("high-at-release-time", time_bcd, 16'h0000);
        check_lit("high-at-release-running", {15'b0, running}, 16'h0001);
        tick_in = 1'b0;
        cyc(4);
        ticks(1, 3, 3);
        check_lit("rerise-counts", time_bcd, 16'h0001);

        // randomized commands, ticks and occasional resets
        repeat (4000) begin
            if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
            start_stop = ($urandom_range(0, 19) == 0);
            clear      = ($urandom_range(0, 149) == 0);
            lap        = ($urandom_range(0, 29) == 0);
            rst        = ($urandom_range(0, 399) == 0);
            @(negedge clk_in);
        end
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        rst        = 1'b0;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
